key_filter_bank: RTL
====================

Name: key_filter_bank

Overview:
Parametrised successor to the per-key debounce filters the top level currently instantiates in separate generate loops. It replaces those with one NUM_KEYS-channel bank that provides input synchronisation, debounce, a debounced level, press and release pulses, and a priority-encoded key code. The bank sits between the board buttons/switches and the vending state machine. Money, function and goods keys each use one instance.

Parameters:
NUM_KEYS, 5, number of independent key channels (>=1)
DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required to accept a level change (>=1; 20 ms at 100 MHz)
ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; the bank normalises internally so pressed = 1
REPEAT_DELAY, 50000000, cycles from first press pulse to first repeat pulse (used only with the macro)
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (used only with the macro)

Ports:
sys_clk  in  1  single system clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
key_in  in  NUM_KEYS  raw asynchronous key pins
key_level  out  NUM_KEYS  debounced pressed level per channel
key_posedge  out  NUM_KEYS  one-cycle press pulse per channel
key_negedge  out  NUM_KEYS  one-cycle release pulse per channel
key_valid  out  1  OR of key_posedge
key_code  out  max(1,$clog2(NUM_KEYS))  index of lowest-numbered channel with key_posedge set; 0 when key_valid=0

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - Synchroniser stages are set to the not-pressed level.
  - Counters are cleared.
  - key_level, key_posedge and key_negedge are all 0, so key_valid=0 and key_code=0.
  - Reset overrides all other activity.
- Per channel, a 2-flop synchroniser feeds normalised raw pressed value r (r = key_in XOR ACTIVE_LOW, then synchronised).
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
  - When r != key_level, the counter increments each cycle.
  - Any cycle with r == key_level clears the counter to 0.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, key_level toggles and the counter clears in the same edge.
- Latency: a pin change first sampled at edge 0 shows on key_level after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges including edge 0. Press and release latency are identical.
- Pulses:
  - key_posedge[i] is registered. It is 1 for exactly the one cycle in which key_level[i] first reads 1.
  - key_negedge[i] likewise marks the first cycle in which key_level[i] reads 0.
- Glitches: a differing pulse shorter than DEBOUNCE_CYCLES cycles produces no output. Any bounce restarts the count.
- key_valid and key_code are combinational from the key_posedge registers, with no extra latency.
- Simultaneous presses:
  - All affected bits of key_posedge assert together.
  - key_code reports the lowest index.
  - Nothing is queued.
- Channels are fully independent; activity on one never affects another channel's counter.
- A key held through reset release is treated as a new press: key_posedge follows DEBOUNCE_CYCLES+2 edges after the first edge with sys_rst=0.
- Counters saturate structurally: the counter never exceeds DEBOUNCE_CYCLES, so there is no wrap.

Optional Feature:
Macro KEY_FILTER_REPEAT_EN.
- Defined:
  - Each channel gets a hold counter that starts at the press pulse.
  - While key_level[i]=1, key_posedge[i] re-pulses for one cycle REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - key_valid and key_code follow these pulses.
  - Release clears the hold counter immediately. key_negedge is unaffected.
  - Reset clears the hold counters.
- Undefined:
  - No hold counters are synthesised.
  - Exactly one key_posedge pulse per debounced press.
  - The REPEAT_* parameters are ignored.

Test Plan (NUM_KEYS=5, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated):
1. Reset: hold sys_rst=1 for 3 cycles with key_in=5'b11111, then release -> all outputs 0 during reset. key_posedge=5'b11111, key_code=0, key_valid=1 for one cycle on the 6th edge after reset deasserts.
2. Clean press ch2: key_in[2] 0->1 held 20 cycles, then 1->0 -> key_posedge[2] pulses 6 edges after the rise, key_code=2, key_level[2]=1 until key_negedge[2] pulses 6 edges after the fall.
3. Bounce ch0: a 3-cycle high glitch, then toggling every 2 cycles for 20 cycles, then stable high -> no output from the glitch or the toggling. Exactly one key_posedge[0], 6 edges after the last transition.
4. Simultaneous ch1+ch3 rising on the same edge -> key_posedge=5'b01010 for one cycle, key_code=1, key_valid=1. Other channels stay 0.
5. Reset mid-count: ch4 held, sys_rst=1 when its counter=3 -> no pulse. key_posedge[4] pulses 6 edges after sys_rst returns to 0.
6. ACTIVE_LOW=1 with KEY_FILTER_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5: key_in[0] driven 1->0 and held 40 cycles -> key_posedge[0] pulses at t, t+10, t+15, t+20... until release. Key_negedge[0] pulses once, 6 edges after the pin returns to 1.

Source files
------------

// File: rtl/key_filter_bank.sv
// Multi-channel key conditioner: 2-flop sync, debounce, level and edge pulses, priority code.
// Define KEY_FILTER_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_filter_bank #(
  parameter int unsigned NUM_KEYS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  localparam int unsigned CodeW          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_posedge,
  output logic [NUM_KEYS-1:0] key_negedge,
  output logic                key_valid,
  output logic [CodeW-1:0]    key_code
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  if (NUM_KEYS == 0 || DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)
  begin : g_param_check
    $error("key_filter_bank: NUM_KEYS, DEBOUNCE_CYCLES and REPEAT_* must all be >= 1");
  end

`ifdef KEY_FILTER_REPEAT_EN
  localparam int unsigned     HoldMax    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
  localparam int unsigned     HoldW      = (HoldMax > 1) ? $clog2(HoldMax) : 1;
  localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);
`endif

  // Normalise polarity before synchronising so reset can clear to "not pressed" = 0.
  logic [NUM_KEYS-1:0] key_norm;
  assign key_norm = key_in ^ {NUM_KEYS{ACTIVE_LOW}};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    logic            sync1_q, sync2_q;
    logic            level_q, pos_q, neg_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            differ, accept, rep_fire;

    assign differ = sync2_q ^ level_q;
    // The counter tops out at DEBOUNCE_CYCLES-1; the next differing cycle accepts and clears.
    assign accept = differ && (cnt_q == CntLast);

    always_comb begin
      cnt_d = '0;
      if (differ && !accept) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef KEY_FILTER_REPEAT_EN
    logic [HoldW-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;

    // hold_q counts cycles since the last press/repeat pulse; rep_q selects delay vs period.
    always_comb begin
      hold_d   = hold_q;
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (!level_q || accept) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (hold_q == (rep_q ? PeriodLast : DelayLast)) begin
        rep_fire = 1'b1;
        hold_d   = '0;
        rep_d    = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
      end else begin
        sync1_q <= key_norm[i];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        level_q <= level_q ^ accept;
        pos_q   <= (accept && !level_q) || rep_fire;
        neg_q   <= accept && level_q;
      end
    end

    assign key_level[i]   = level_q;
    assign key_posedge[i] = pos_q;
    assign key_negedge[i] = neg_q;
  end

  assign key_valid = |key_posedge;

  // Scan from the top so the lowest-numbered active channel wins.
  always_comb begin
    key_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_posedge[i]) begin
        key_code = CodeW'(i);
      end
    end
  end

endmodule
